// File: rtl/com_dummy_pkg.sv
// Shared defaults and types for the com_dummy traffic self-check block.
package com_dummy_pkg;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);

  typedef logic [DW-1:0] data_t;

endpackage

// File: rtl/com_sync_fifo_reg.sv
// Register-array synchronous FIFO with first-word-fall-through head read and
// registered full/empty/level status derived from the next-state level.
module com_sync_fifo_reg #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DW-1:0]                wr_data_i,
  output logic [DW-1:0]                head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push_ok, pop_ok;

  // Requests are qualified against the status registered at cycle start, so a
  // push into a full FIFO is refused even when a pop happens in the same cycle.
  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
    else if (!push_ok && pop_ok) level_d = level_q - LW'(1);
    full_d  = (level_d == FULL_LVL);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk) begin
    if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: words are only observed through a qualified pop.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/com_dummy_unit.sv
// Traffic dummy: a counter generator feeds a sync FIFO, a checker pops words
// and compares them against an expected counter, keeping pass/error statistics.
module com_dummy_unit
  import com_dummy_pkg::*;
#(
  parameter int DW    = com_dummy_pkg::DW,
  parameter int DEPTH = com_dummy_pkg::DEPTH,
  parameter int CNT_W = com_dummy_pkg::CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       gen_en,
  input  logic                       inject_err,
  input  logic                       chk_en,
  output logic                       wr_full,
  output logic                       rd_empty,
  output logic [$clog2(DEPTH+1)-1:0] water_level,
  output logic [DW-1:0]              rd_data,
  output logic                       rd_vld,
  output logic                       err_sticky,
  output logic [CNT_W-1:0]           err_cnt,
  output logic [CNT_W-1:0]           pass_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             srst;
  logic             push, pop;
  logic [DW-1:0]    head, wr_word;
  logic [DW-1:0]    gen_q, gen_d;
  logic [DW-1:0]    exp_q, exp_d;
  logic [DW-1:0]    rd_data_q, rd_data_d;
  logic             rd_vld_q, rd_vld_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;

  assign srst    = rst | clear;
  assign push    = gen_en & ~wr_full;
  assign pop     = chk_en & ~rd_empty;
  assign wr_word = inject_err ? (gen_q ^ DW'(1)) : gen_q;

  com_sync_fifo_reg #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clear_i   (srst),
    .push_i    (push),
    .pop_i     (pop),
    .wr_data_i (wr_word),
    .head_o    (head),
    .full_o    (wr_full),
    .empty_o   (rd_empty),
    .level_o   (water_level)
  );

  always_comb begin
    gen_d        = gen_q;
    exp_d        = exp_q;
    rd_data_d    = rd_data_q;
    rd_vld_d     = 1'b0;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    pass_cnt_d   = pass_cnt_q;
    if (push) gen_d = gen_q + DW'(1);
    // The expected counter advances on every pop so one bad word is one error.
    if (pop) begin
      exp_d     = exp_q + DW'(1);
      rd_data_d = head;
      rd_vld_d  = 1'b1;
      if (head == exp_q) begin
        if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_W'(1);
      end else begin
        err_sticky_d = 1'b1;
        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      gen_q        <= '0;
      exp_q        <= '0;
      rd_data_q    <= '0;
      rd_vld_q     <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
      pass_cnt_q   <= '0;
    end else begin
      gen_q        <= gen_d;
      exp_q        <= exp_d;
      rd_data_q    <= rd_data_d;
      rd_vld_q     <= rd_vld_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      pass_cnt_q   <= pass_cnt_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_vld     = rd_vld_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign pass_cnt   = pass_cnt_q;

endmodule

// File: tb/tb_com_dummy_unit.sv
// Bench for com_dummy_unit: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_com_dummy_unit;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int LW    = 3;

  logic             clk = 1'b0;
  logic             rst, clear, gen_en, inject_err, chk_en;
  logic             wr_full, rd_empty, rd_vld, err_sticky;
  logic [LW-1:0]    water_level;
  logic [DW-1:0]    rd_data;
  logic [CNT_W-1:0] err_cnt, pass_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue plus plain integer counters.
  logic [DW-1:0] exp_q[$];
  int            m_gen, m_exp, m_pass, m_err;
  logic [DW-1:0] m_rd;
  logic          m_vld, m_sticky;

  typedef struct {
    logic          g;
    logic          inj;
    logic          c;
    int            lvl;
    logic          full;
    logic          empty;
    logic          vld;
    logic [DW-1:0] rd;
    int            pass;
    int            err;
  } vec_t;

  vec_t vecs[13];

  com_dummy_unit #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .gen_en      (gen_en),
    .inject_err  (inject_err),
    .chk_en      (chk_en),
    .wr_full     (wr_full),
    .rd_empty    (rd_empty),
    .water_level (water_level),
    .rd_data     (rd_data),
    .rd_vld      (rd_vld),
    .err_sticky  (err_sticky),
    .err_cnt     (err_cnt),
    .pass_cnt    (pass_cnt)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_step(input logic g, input logic inj, input logic c,
                            input logic cl, input logic r);
    int            sz;
    logic [DW-1:0] w;
    if (r || cl) begin
      exp_q.delete();
      m_gen = 0; m_exp = 0; m_pass = 0; m_err = 0;
      m_rd = '0; m_vld = 1'b0; m_sticky = 1'b0;
    end else begin
      sz = exp_q.size();
      if (c && sz > 0) begin
        w     = exp_q.pop_front();
        m_rd  = w;
        m_vld = 1'b1;
        if (int'(w) == m_exp) m_pass = (m_pass < 65535) ? m_pass + 1 : m_pass;
        else begin
          m_err    = (m_err < 65535) ? m_err + 1 : m_err;
          m_sticky = 1'b1;
        end
        m_exp = (m_exp + 1) % 256;
      end else begin
        m_vld = 1'b0;
      end
      if (g && sz < DEPTH) begin
        exp_q.push_back(inj ? DW'(m_gen ^ 1) : DW'(m_gen));
        m_gen = (m_gen + 1) % 256;
      end
    end
  endtask

  // driver: called at a falling edge, returns at the next falling edge
  task automatic cycle(input logic g, input logic inj, input logic c,
                       input logic cl, input logic r);
    gen_en = g; inject_err = inj; chk_en = c; clear = cl; rst = r;
    @(posedge clk);
    model_step(g, inj, c, cl, r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    rst = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_level"}, int'(water_level), exp_q.size());
    chk({tag, "_full"},  int'(wr_full),  int'(exp_q.size() == DEPTH));
    chk({tag, "_empty"}, int'(rd_empty), int'(exp_q.size() == 0));
    chk({tag, "_rd_data"}, int'(rd_data), int'(m_rd));
    chk({tag, "_rd_vld"},  int'(rd_vld),  int'(m_vld));
    chk({tag, "_sticky"},  int'(err_sticky), int'(m_sticky));
    chk({tag, "_err_cnt"}, int'(err_cnt), m_err);
    chk({tag, "_pass_cnt"}, int'(pass_cnt), m_pass);
  endtask

  initial begin
    logic [DW-1:0] prev_rd;
    logic          saw_wrap;
    rst = 1'b1; clear = 1'b0; gen_en = 1'b0; inject_err = 1'b0; chk_en = 1'b0;
    @(negedge clk);

    // reset state
    do_reset();
    chk("reset_empty", int'(rd_empty), 1);
    chk("reset_full", int'(wr_full), 0);
    chk("reset_level", int'(water_level), 0);
    chk("reset_pass", int'(pass_cnt), 0);
    chk("reset_err", int'(err_cnt), 0);
    chk("reset_sticky", int'(err_sticky), 0);
    chk("reset_vld", int'(rd_vld), 0);

    // fill 6, drain 5, then one push/pop to show the next word is 4
    vecs[0]  = '{1, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0};
    vecs[1]  = '{1, 0, 0, 2, 0, 0, 0, 8'h00, 0, 0};
    vecs[2]  = '{1, 0, 0, 3, 0, 0, 0, 8'h00, 0, 0};
    vecs[3]  = '{1, 0, 0, 4, 1, 0, 0, 8'h00, 0, 0};
    vecs[4]  = '{1, 0, 0, 4, 1, 0, 0, 8'h00, 0, 0};
    vecs[5]  = '{1, 0, 0, 4, 1, 0, 0, 8'h00, 0, 0};
    vecs[6]  = '{0, 0, 1, 3, 0, 0, 1, 8'h00, 1, 0};
    vecs[7]  = '{0, 0, 1, 2, 0, 0, 1, 8'h01, 2, 0};
    vecs[8]  = '{0, 0, 1, 1, 0, 0, 1, 8'h02, 3, 0};
    vecs[9]  = '{0, 0, 1, 0, 0, 1, 1, 8'h03, 4, 0};
    vecs[10] = '{0, 0, 1, 0, 0, 1, 0, 8'h03, 4, 0};
    vecs[11] = '{1, 0, 0, 1, 0, 0, 0, 8'h03, 4, 0};
    vecs[12] = '{0, 0, 1, 0, 0, 1, 1, 8'h04, 5, 0};
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].g, vecs[i].inj, vecs[i].c, 0, 0);
      chk($sformatf("vec%0d_level", i), int'(water_level), vecs[i].lvl);
      chk($sformatf("vec%0d_full", i), int'(wr_full), int'(vecs[i].full));
      chk($sformatf("vec%0d_empty", i), int'(rd_empty), int'(vecs[i].empty));
      chk($sformatf("vec%0d_vld", i), int'(rd_vld), int'(vecs[i].vld));
      chk($sformatf("vec%0d_rd_data", i), int'(rd_data), int'(vecs[i].rd));
      chk($sformatf("vec%0d_pass", i), int'(pass_cnt), vecs[i].pass);
      chk($sformatf("vec%0d_err", i), int'(err_cnt), vecs[i].err);
    end

    // push+pop while full: push refused, pop taken
    do_reset();
    repeat (4) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0);
    chk("fullpp_level", int'(water_level), 3);
    chk("fullpp_rd", int'(rd_data), 0);
    cycle(1, 0, 0, 0, 0);
    check_all("fullpp_push");
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 0, 0);
      check_all("fullpp_drain");
      chk("fullpp_drain_word", int'(rd_data), i + 1);
    end

    // streaming with wrap
    do_reset();
    saw_wrap = 1'b0;
    prev_rd  = '0;
    for (int i = 0; i < 300; i++) begin
      cycle(1, 0, 1, 0, 0);
      check_all("stream");
      if (rd_vld && prev_rd == 8'hFF && rd_data == 8'h00) saw_wrap = 1'b1;
      if (rd_vld) prev_rd = rd_data;
    end
    chk("stream_level", int'(water_level), 1);
    chk("stream_pass", int'(pass_cnt), 299);
    chk("stream_err", int'(err_cnt), 0);
    chk("stream_wrap", int'(saw_wrap), 1);

    // inject on the push of value 5
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(1, k == 5, 1, 0, 0);
      check_all("inject");
      if (k == 6) begin
        chk("inject_rd", int'(rd_data), 8'h04);
        chk("inject_sticky", int'(err_sticky), 1);
        chk("inject_err", int'(err_cnt), 1);
        chk("inject_pass", int'(pass_cnt), 5);
      end
      if (k == 7) begin
        chk("inject_next_rd", int'(rd_data), 8'h06);
        chk("inject_next_pass", int'(pass_cnt), 6);
        chk("inject_next_err", int'(err_cnt), 1);
      end
    end

    // soft clear at level 3 with err_sticky set
    do_reset();
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    repeat (3) cycle(1, 0, 0, 0, 0);
    chk("clr_pre_level", int'(water_level), 3);
    chk("clr_pre_sticky", int'(err_sticky), 1);
    cycle(0, 0, 0, 1, 0);
    chk("clr_level", int'(water_level), 0);
    chk("clr_empty", int'(rd_empty), 1);
    chk("clr_sticky", int'(err_sticky), 0);
    chk("clr_err", int'(err_cnt), 0);
    chk("clr_pass", int'(pass_cnt), 0);
    chk("clr_rd", int'(rd_data), 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk("clr_first_word", int'(rd_data), 8'h00);
    chk("clr_first_pass", int'(pass_cnt), 1);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0),
            1'($urandom_range(0, 127) == 0));
      check_all("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
